stopwatch_ctrl: RTL and testbench

Control front end for the MM:SS stopwatch display. It debounces the start/stop and clear pushbuttons and runs the IDLE/RUN/PAUSE state machine. It generates the one-cycle 1 Hz count-enable pulse and the counter clear pulse that drive the seconds/minutes digit counters, plus a free-running digit-scan tick for the display multiplexer. It sits directly upstream of the display block: `cnt_en` feeds its `en` input, and `cnt_clr` is ORed into its counter reset.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/stopwatch_ctrl.sv | 114 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default timing constants for the stopwatch control path.
// Defaults target a 50 MHz system clock.
package stopwatch_pkg;

    localparam int CLK_HZ     = 50_000_000;
    localparam int TICK_DIV   = CLK_HZ;
    localparam int DEB_CYCLES = 500_000;
    localparam int SCAN_DIV   = 50_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton path: 2-FF synchronizer, stable-count debouncer and a
// single-cycle press strobe on each rising edge of the debounced level.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = stopwatch_pkg::DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int            CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            level_d <= level;
            // Any cycle where the input agrees with the level restarts the count.
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: button debouncing, IDLE/RUN/PAUSE FSM,
// 1 Hz count-enable prescaler, counter clear strobe and display scan tick.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = stopwatch_pkg::TICK_DIV,
    parameter int DEB_CYCLES = stopwatch_pkg::DEB_CYCLES,
    parameter int SCAN_DIV   = stopwatch_pkg::SCAN_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       scan_tick,
    output logic       running,
    output logic [1:0] state
);

    localparam int            PW         = cnt_width(TICK_DIV);
    localparam int            SW         = cnt_width(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    logic start_press;
    logic clear_press;
    logic start_level;
    logic clear_level;
    logic unused_levels;

    state_t        state_q;
    state_t        state_nxt;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_nxt;
    logic [SW-1:0] scan_q;
    logic [SW-1:0] scan_nxt;
    logic          cnt_en_nxt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_start_stop),
        .level   (start_level),
        .press   (start_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clear),
        .level   (clear_level),
        .press   (clear_press)
    );

    assign unused_levels = start_level ^ clear_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Clear outranks start when both presses land in the same cycle.
    always_comb begin
        state_nxt = state_q;
        if (clear_press) begin
            state_nxt = ST_IDLE;
        end else if (start_press) begin
            case (state_q)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running   = (state_q == ST_RUN);
        presc_nxt = '0;
        if (!clear_press) begin
            case (state_q)
                ST_RUN:   presc_nxt = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
                ST_PAUSE: presc_nxt = presc_q;
                default:  presc_nxt = '0;
            endcase
        end
        scan_nxt   = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
        // Registered from next-state values so cnt_en lines up with RUN && presc==last.
        cnt_en_nxt = (state_nxt == ST_RUN) && (presc_nxt == PRESC_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            scan_q    <= '0;
            cnt_en    <= 1'b0;
            cnt_clr   <= 1'b0;
            scan_tick <= 1'b0;
        end else begin
            presc_q   <= presc_nxt;
            scan_q    <= scan_nxt;
            cnt_en    <= cnt_en_nxt;
            cnt_clr   <= clear_press;
            scan_tick <= (scan_nxt == SCAN_LAST);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DEB_CYCLES=4, SCAN_DIV=5.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_ctrl;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start_stop;
    logic       btn_clear;
    logic       cnt_en;
    logic       cnt_clr;
    logic       scan_tick;
    logic       running;
    logic [1:0] state;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt_pulses;
    int clr_pulses;
    logic [15:0] bounce_pat;

    stopwatch_ctrl #(
        .TICK_DIV   (10),
        .DEB_CYCLES (4),
        .SCAN_DIV   (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .cnt_en         (cnt_en),
        .cnt_clr        (cnt_clr),
        .scan_tick      (scan_tick),
        .running        (running),
        .state          (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        cyc(2);
        chk("rst_state", state, S_IDLE);
        chk("rst_running", running, 0);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_cnt_clr", cnt_clr, 0);
        chk("rst_scan_tick", scan_tick, 0);
        rst = 1'b0;

        // Idle: scan tick on every 5th cycle, nothing else moves.
        for (int i = 1; i <= 100; i++) begin
            cyc();
            chk("idle_scan_tick", scan_tick, (i % 5 == 4) ? 1 : 0);
            chk("idle_cnt_en", cnt_en, 0);
            chk("idle_cnt_clr", cnt_clr, 0);
            chk("idle_state", state, S_IDLE);
        end

        // Start press: 2 sync + 4 debounce, press cycle, state changes next edge.
        btn_start_stop = 1'b1;
        cyc(6);
        chk("start_before_run", state, S_IDLE);
        cyc();
        chk("start_run_state", state, S_RUN);
        chk("start_running", running, 1);
        cnt_pulses = 0;
        for (int k = 1; k <= 50; k++) begin
            if (k != 1) cyc();
            if (k == 13) btn_start_stop = 1'b0;
            chk("run_cnt_en", cnt_en, (k % 10 == 0) ? 1 : 0);
            cnt_pulses += int'(cnt_en);
        end
        chk("run_pulse_count", cnt_pulses, 5);

        // Pause with presc=6 in the press cycle; presc holds at 7.
        cyc();
        chk("run_after_wrap_cnt_en", cnt_en, 0);
        btn_start_stop = 1'b1;
        cyc(6);
        chk("pause_press_cycle_state", state, S_RUN);
        cyc();
        chk("pause_state", state, S_PAUSE);
        chk("pause_running", running, 0);
        btn_start_stop = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            chk("pause_hold_state", state, S_PAUSE);
            chk("pause_no_cnt_en", cnt_en, 0);
        end
        btn_start_stop = 1'b1;
        cyc(6);
        chk("resume_press_cycle_state", state, S_PAUSE);
        cyc();
        chk("resume_state", state, S_RUN);
        chk("resume_cnt_en_1", cnt_en, 0);
        btn_start_stop = 1'b0;
        cyc();
        chk("resume_cnt_en_2", cnt_en, 0);
        cyc();
        chk("resume_cnt_en_3", cnt_en, 1);
        cyc();
        chk("resume_cnt_en_4", cnt_en, 0);

        // Bounce: high runs of 1..3 cycles never reach the debounce threshold.
        bounce_pat = 16'b0111_0001_1011_1001;
        for (int b = 0; b < 16; b++) begin
            btn_start_stop = bounce_pat[b];
            cyc();
            chk("bounce_state", state, S_RUN);
        end
        btn_start_stop = 1'b0;
        for (int b = 0; b < 8; b++) begin
            cyc();
            chk("bounce_settle_state", state, S_RUN);
        end
        btn_start_stop = 1'b1;
        cyc(6);
        chk("stable_before", state, S_RUN);
        cyc();
        chk("stable_pause", state, S_PAUSE);
        for (int b = 0; b < 12; b++) begin
            cyc();
            chk("stable_single_transition", state, S_PAUSE);
        end
        btn_start_stop = 1'b0;
        cyc(8);

        // Back to RUN, then start and clear together.
        btn_start_stop = 1'b1;
        cyc(7);
        chk("rerun_state", state, S_RUN);
        btn_start_stop = 1'b0;
        cyc(8);
        btn_start_stop = 1'b1;
        btn_clear = 1'b1;
        cyc(6);
        chk("both_before_state", state, S_RUN);
        chk("both_before_cnt_clr", cnt_clr, 0);
        cyc();
        chk("both_state_idle", state, S_IDLE);
        chk("both_cnt_clr", cnt_clr, 1);
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        clr_pulses = 1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk("both_after_state", state, S_IDLE);
            chk("both_after_cnt_en", cnt_en, 0);
            clr_pulses += int'(cnt_clr);
        end
        chk("both_clr_pulse_count", clr_pulses, 1);

        // Clear while already idle still pulses cnt_clr.
        btn_clear = 1'b1;
        cyc(6);
        chk("idle_clear_before", cnt_clr, 0);
        cyc();
        chk("idle_clear_pulse", cnt_clr, 1);
        chk("idle_clear_state", state, S_IDLE);
        cyc();
        chk("idle_clear_width", cnt_clr, 0);
        btn_clear = 1'b0;
        cyc(8);

        // Pause press landing on the terminal cycle: cnt_en fires, presc wraps.
        btn_start_stop = 1'b1;
        cyc(7);
        chk("term_run_state", state, S_RUN);
        btn_start_stop = 1'b0;
        cyc(9);
        chk("term_first_cnt_en", cnt_en, 1);
        cyc(4);
        btn_start_stop = 1'b1;
        cyc(5);
        chk("term_cycle19_cnt_en", cnt_en, 0);
        cyc();
        chk("term_cnt_en", cnt_en, 1);
        chk("term_state_run", state, S_RUN);
        cyc();
        chk("term_pause_state", state, S_PAUSE);
        chk("term_pause_cnt_en", cnt_en, 0);
        btn_start_stop = 1'b0;
        cyc(8);
        btn_start_stop = 1'b1;
        cyc(7);
        chk("term_resume_state", state, S_RUN);
        chk("term_resume_cnt_en", cnt_en, 0);
        btn_start_stop = 1'b0;
        for (int j = 2; j <= 18; j++) begin
            cyc();
            chk("term_resume_period", cnt_en, (j == 10) ? 1 : 0);
        end

        // Reset for one cycle mid-RUN at presc=7.
        rst = 1'b1;
        cyc();
        chk("midrst_state", state, S_IDLE);
        chk("midrst_running", running, 0);
        chk("midrst_cnt_en", cnt_en, 0);
        chk("midrst_cnt_clr", cnt_clr, 0);
        chk("midrst_scan_tick", scan_tick, 0);
        rst = 1'b0;
        btn_start_stop = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i == 7) btn_start_stop = 1'b0;
            chk("post_rst_scan_tick", scan_tick, (i % 5 == 4) ? 1 : 0);
            chk("post_rst_state", state, (i >= 7) ? S_RUN : S_IDLE);
            chk("post_rst_cnt_en", cnt_en, (i == 16) ? 1 : 0);
            chk("post_rst_cnt_clr", cnt_clr, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
